kv_cache_ctrl: RTL



---
 rtl/kv_cache_pkg.sv | 32 +++
 rtl/kv_cache_tagarray.sv | 48 ++++
 rtl/kv_cache_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/kv_cache_pkg.sv
// kv_cache_pkg: shared state encoding, width helpers and one-hot priority helper for the cache controller
package kv_cache_pkg;

    localparam int MAX_WAYS = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        MISS_REQ,
        MISS_WAIT,
        RESP,
        FLUSH
    } state_t;

    function automatic int index_width(input int way_num, input int line_num);
        return $clog2(line_num / way_num);
    endfunction

    function automatic int offset_width(input int line_bytes);
        return $clog2(line_bytes);
    endfunction

    function automatic int tag_width(input int addr_width, input int way_num, input int line_num, input int line_bytes);
        return addr_width - index_width(way_num, line_num) - offset_width(line_bytes);
    endfunction

    // Lowest set bit as one-hot; an empty vector selects bit n-1 (the top way).
    function automatic logic [MAX_WAYS-1:0] onehot_lowest(input logic [MAX_WAYS-1:0] v, input int unsigned n);
        return (v == '0) ? (MAX_WAYS'(1) << (n - 1)) : (v & (~v + MAX_WAYS'(1)));
    endfunction

endpackage

// File: rtl/kv_cache_tagarray.sv
// kv_cache_tagarray: per-set tag storage plus valid bits with async clear, one read, one write and a set-clear port
module kv_cache_tagarray
    import kv_cache_pkg::*;
#(
    parameter int WAY_NUM = 4,
    parameter int SETS = 16,
    parameter int INDEX_WIDTH = 4,
    parameter int TAG_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [INDEX_WIDTH-1:0]         rd_index,
    output logic [WAY_NUM*TAG_WIDTH-1:0]   rd_tags,
    output logic [WAY_NUM-1:0]             rd_valid,
    input  logic                           we,
    input  logic [INDEX_WIDTH-1:0]         wr_index,
    input  logic [WAY_NUM-1:0]             wr_way,
    input  logic [TAG_WIDTH-1:0]           wr_tag,
    input  logic                           clr,
    input  logic [INDEX_WIDTH-1:0]         clr_index
);

    logic [TAG_WIDTH-1:0] tags [SETS][WAY_NUM];
    logic [WAY_NUM-1:0]   valid [SETS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) valid[s] <= '0;
        end else begin
            if (clr) valid[clr_index] <= '0;
            if (we) valid[wr_index] <= valid[wr_index] | wr_way;
        end
    end

    // Tags carry no reset; a line only counts once its valid bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int w = 0; w < WAY_NUM; w++) if (wr_way[w]) tags[wr_index][w] <= wr_tag;
        end
    end

    always_comb begin
        rd_tags = '0;
        for (int w = 0; w < WAY_NUM; w++) rd_tags[w*TAG_WIDTH +: TAG_WIDTH] = tags[rd_index][w];
        rd_valid = valid[rd_index];
    end

endmodule

// File: rtl/kv_cache_ctrl.sv
// kv_cache_ctrl: lookup / refill / flush sequencer for one set-associative cache with external LRU and data RAM
module kv_cache_ctrl
    import kv_cache_pkg::*;
#(
    parameter int WAY_NUM = 4,
    parameter int LINE_NUM = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 16,
    localparam int SETS = LINE_NUM / WAY_NUM,
    localparam int INDEX_WIDTH = index_width(WAY_NUM, LINE_NUM),
    localparam int OFFSET_WIDTH = offset_width(LINE_BYTES),
    localparam int TAG_WIDTH = tag_width(ADDR_WIDTH, WAY_NUM, LINE_NUM, LINE_BYTES)
) (
    input  logic                   i_clk,
    input  logic                   i_rstn,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [ADDR_WIDTH-1:0]  i_req_addr,
    input  logic                   i_flush,
    output logic                   o_flush_done,
    output logic                   o_rsp_valid,
    output logic                   o_rsp_hit,
    output logic [WAY_NUM-1:0]     o_rsp_way,
    output logic [INDEX_WIDTH-1:0] o_lru_index,
    output logic [WAY_NUM-1:0]     o_lru_valid_way,
    output logic [WAY_NUM-1:0]     o_lru_hitway,
    input  logic [WAY_NUM-1:0]     i_lru_killmask,
    output logic                   o_mem_req_valid,
    input  logic                   i_mem_req_ready,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_rsp_valid,
    output logic                   o_data_we,
    output logic [WAY_NUM-1:0]     o_data_way,
    output logic [INDEX_WIDTH-1:0] o_data_index
);

    state_t                       state, state_n;
    logic [TAG_WIDTH-1:0]         tag_q;
    logic [INDEX_WIDTH-1:0]       index_q, flush_cnt;
    logic [WAY_NUM-1:0]           way_q, hit_vec, rd_valid, free_ways;
    logic [WAY_NUM*TAG_WIDTH-1:0] rd_tags;
    logic [MAX_WAYS-1:0]          hit_wide, victim_wide;
    logic                         hit_q, clr, last_set, unused_bits;

    kv_cache_tagarray #(
        .WAY_NUM(WAY_NUM), .SETS(SETS), .INDEX_WIDTH(INDEX_WIDTH), .TAG_WIDTH(TAG_WIDTH)
    ) u_tags (
        .clk(i_clk), .rst_n(i_rstn),
        .rd_index(index_q), .rd_tags(rd_tags), .rd_valid(rd_valid),
        .we(o_data_we), .wr_index(index_q), .wr_way(way_q), .wr_tag(tag_q),
        .clr(clr), .clr_index(flush_cnt)
    );

    always_comb begin
        hit_vec = '0;
        for (int w = 0; w < WAY_NUM; w++) hit_vec[w] = rd_valid[w] && rd_tags[w*TAG_WIDTH +: TAG_WIDTH] == tag_q;
    end

    // Victim: lowest invalid way first, otherwise the LRU kill mask (empty mask falls to the top way).
    assign free_ways   = ~rd_valid;
    assign hit_wide    = onehot_lowest(MAX_WAYS'(hit_vec), WAY_NUM);
    assign victim_wide = onehot_lowest(MAX_WAYS'(|free_ways ? free_ways : i_lru_killmask), WAY_NUM);
    assign unused_bits = ^{i_req_addr[OFFSET_WIDTH-1:0], hit_wide[MAX_WAYS-1:WAY_NUM], victim_wide[MAX_WAYS-1:WAY_NUM]};
    assign last_set    = flush_cnt == INDEX_WIDTH'(SETS - 1);

    assign o_req_ready     = i_rstn && state == IDLE && !i_flush;
    assign o_lru_index     = index_q;
    assign o_lru_valid_way = rd_valid;
    assign o_lru_hitway    = o_rsp_valid ? way_q : '0;
    assign o_rsp_way       = o_rsp_valid ? way_q : '0;
    assign o_rsp_hit       = o_rsp_valid && hit_q;
    assign o_mem_addr      = {tag_q, index_q, {OFFSET_WIDTH{1'b0}}};
    assign o_data_way      = o_data_we ? way_q : '0;
    assign o_data_index    = index_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n         = state;
        o_mem_req_valid = 1'b0;
        o_data_we       = 1'b0;
        o_rsp_valid     = 1'b0;
        o_flush_done    = 1'b0;
        clr             = 1'b0;
        case (state)
            IDLE:      state_n = i_flush ? FLUSH : (i_req_valid ? LOOKUP : IDLE);
            LOOKUP:    state_n = |hit_vec ? RESP : MISS_REQ;
            MISS_REQ: begin
                o_mem_req_valid = 1'b1;
                state_n = i_mem_req_ready ? MISS_WAIT : MISS_REQ;
            end
            MISS_WAIT: begin
                o_data_we = i_mem_rsp_valid;
                state_n = i_mem_rsp_valid ? RESP : MISS_WAIT;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                state_n = IDLE;
            end
            FLUSH: begin
                clr = 1'b1;
                o_flush_done = last_set;
                state_n = last_set ? IDLE : FLUSH;
            end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tag_q     <= '0;
            index_q   <= '0;
            way_q     <= '0;
            hit_q     <= 1'b0;
            flush_cnt <= '0;
        end else begin
            if (o_req_ready && i_req_valid) {tag_q, index_q} <= i_req_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
            if (state == LOOKUP) begin
                hit_q <= |hit_vec;
                way_q <= |hit_vec ? hit_wide[WAY_NUM-1:0] : victim_wide[WAY_NUM-1:0];
            end
            if (clr) flush_cnt <= flush_cnt + INDEX_WIDTH'(1);
        end
    end

endmodule
